photon_bin_counter: RTL and testbench

- Sits directly downstream of the ADC threshold discriminator, which emits a one-cycle `event_in` strobe per detected photon.
- Counts events in consecutive gated time bins of programmable length after a trigger.
- Tags each bin's count with its bin index and streams the words out over AXI-Stream through a small FIFO, for DMA/readout.
- Reports busy, done and sticky overflow status.

---
 rtl/photon_bin_counter.sv | 148 ++++++++++++++
 tb/tb_photon_bin_counter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_bin_counter.sv
// Gated photon-event bin counter: counts discriminator strobes in consecutive
// fixed-length time bins after a trigger and streams {bin_idx, count} words
// out over AXI-Stream through a small first-word-fall-through FIFO.
module photon_bin_counter #(
  parameter int unsigned COUNT_WIDTH      = 24,
  parameter int unsigned BIN_IDX_WIDTH    = 8,
  parameter int unsigned GATE_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        event_in,
  input  logic                        trigger,
  input  logic [GATE_WIDTH-1:0]       gate_len,
  input  logic [BIN_IDX_WIDTH-1:0]    num_bins,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                     state, state_d;
  logic [GATE_WIDTH-1:0]      gate_cnt, gate_cnt_d;
  logic [GATE_WIDTH-1:0]      gate_m1, gate_m1_d;
  logic [BIN_IDX_WIDTH-1:0]   bin_idx, bin_idx_d;
  logic [BIN_IDX_WIDTH-1:0]   bins_m1, bins_m1_d;
  logic [COUNT_WIDTH-1:0]     count, count_d, count_inc;
  logic                       busy_d, done_d;
  logic                       start, push;
  logic [AXIS_TDATA_WIDTH-1:0] push_word;

  logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [LVL_W-1:0]           level;
  logic                       full, pop, wr_en, drop;

  // Next-state logic: acquisition sequencing, bin timing and word formation
  always_comb begin
    state_d    = state;
    gate_cnt_d = gate_cnt;
    gate_m1_d  = gate_m1;
    bin_idx_d  = bin_idx;
    bins_m1_d  = bins_m1;
    count_d    = count;
    done_d     = 1'b0;
    start      = 1'b0;
    push       = 1'b0;
    push_word  = '0;
    count_inc  = (event_in && (count != COUNT_MAX)) ? count + COUNT_WIDTH'(1) : count;
    case (state)
      IDLE: begin
        if (trigger && (num_bins != '0)) begin
          state_d    = COUNT;
          start      = 1'b1;
          gate_cnt_d = '0;
          bin_idx_d  = '0;
          count_d    = '0;
          // Store length-1 so the last-cycle test is a plain compare; 0 acts as 1
          gate_m1_d  = (gate_len == '0) ? '0 : gate_len - GATE_WIDTH'(1);
          bins_m1_d  = num_bins - BIN_IDX_WIDTH'(1);
        end
      end
      COUNT: begin
        count_d = count_inc;
        if (gate_cnt == gate_m1) begin
          push       = 1'b1;
          push_word  = AXIS_TDATA_WIDTH'({bin_idx, count_inc});
          count_d    = '0;
          gate_cnt_d = '0;
          bin_idx_d  = bin_idx + BIN_IDX_WIDTH'(1);
          if (bin_idx == bins_m1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          gate_cnt_d = gate_cnt + GATE_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COUNT);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      gate_m1  <= '0;
      bin_idx  <= '0;
      bins_m1  <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      gate_cnt <= gate_cnt_d;
      gate_m1  <= gate_m1_d;
      bin_idx  <= bin_idx_d;
      bins_m1  <= bins_m1_d;
      count    <= count_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign M_AXIS_OUT_tvalid = (level != '0);
  assign M_AXIS_OUT_tdata  = M_AXIS_OUT_tvalid ? mem[rd_ptr] : '0;
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop   = M_AXIS_OUT_tvalid && M_AXIS_OUT_tready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO storage; contents are qualified by level, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_photon_bin_counter.sv
// Scoreboard bench for photon_bin_counter: expected words are computed from the
// per-cycle event pattern of each acquisition and checked by a separate monitor.
module tb_photon_bin_counter;

  localparam int unsigned CW = 24;
  localparam int unsigned BW = 8;
  localparam int unsigned GW = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned TW = 32;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, event_in, trigger, tready;
  logic [GW-1:0] gate_len;
  logic [BW-1:0] num_bins;
  logic [TW-1:0] tdata;
  logic          tvalid, busy, done, overflow;

  // Narrow instance so count saturation is reachable in a short run
  logic       s_event, s_trigger, s_tvalid, s_busy, s_done, s_overflow;
  logic [7:0] s_gate;
  logic [3:0] s_bins;
  logic [7:0] s_tdata;
  logic [7:0] s_got[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [TW-1:0] sb[$];
  bit ev_q[$];
  logic [TW-1:0] held;
  bit stalled = 0;

  always #4 clk = ~clk;

  photon_bin_counter #(.COUNT_WIDTH(CW), .BIN_IDX_WIDTH(BW), .GATE_WIDTH(GW),
                       .FIFO_DEPTH(FD), .AXIS_TDATA_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .event_in(event_in), .trigger(trigger),
    .gate_len(gate_len), .num_bins(num_bins),
    .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid), .M_AXIS_OUT_tready(tready),
    .busy(busy), .done(done), .overflow(overflow));

  photon_bin_counter #(.COUNT_WIDTH(4), .BIN_IDX_WIDTH(4), .GATE_WIDTH(8),
                       .FIFO_DEPTH(2), .AXIS_TDATA_WIDTH(8)) dut_sat (
    .clk(clk), .rst(rst), .event_in(s_event), .trigger(s_trigger),
    .gate_len(s_gate), .num_bins(s_bins),
    .M_AXIS_OUT_tdata(s_tdata), .M_AXIS_OUT_tvalid(s_tvalid), .M_AXIS_OUT_tready(1'b1),
    .busy(s_busy), .done(s_done), .overflow(s_overflow));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted word and checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (tvalid && stalled) check("tdata_stable", 64'(tdata), 64'(held));
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h, required no word", tdata);
        end else begin
          check("word", 64'(tdata), 64'(sb.pop_front()));
        end
        stalled = 0;
      end else if (tvalid) begin
        held    = tdata;
        stalled = 1;
      end else begin
        stalled = 0;
      end
    end
  end

  // Capture of the narrow instance's output stream
  always @(negedge clk) begin
    if (!rst && s_tvalid) s_got.push_back(s_tdata);
  end

  task automatic fill_rand(input int total, input int pct);
    ev_q.delete();
    for (int i = 0; i < total; i++) ev_q.push_back($urandom_range(99) < pct);
  endtask

  // Reference: bin b owns cycles b*gl+1 .. (b+1)*gl after the trigger edge
  task automatic expect_words(input int gle, input int nb, input int keep);
    for (int b = 0; b < nb; b++) begin
      int c = 0;
      for (int j = 0; j < gle; j++) c += int'(ev_q[b * gle + j]);
      if (c > MAXC) c = MAXC;
      if (b < keep) sb.push_back(TW'({BW'(b), CW'(c)}));
    end
  endtask

  task automatic acquire(input int gl, input int nb, input bit trig_ev,
                         input bit retrig, input bit rand_ready, input int keep);
    int gle, total, busy_seen, done_seen, done_at;
    gle = (gl == 0) ? 1 : gl;
    total = gle * nb;
    expect_words(gle, nb, keep);
    gate_len = GW'(gl);
    num_bins = BW'(nb);
    trigger  = 1'b1;
    event_in = trig_ev;
    step();
    busy_seen = 0;
    done_seen = 0;
    done_at   = -1;
    for (int k = 1; k <= total + 3; k++) begin
      if (busy) busy_seen++;
      if (done) begin
        done_seen++;
        done_at = k;
      end
      if (k == 1 && nb != 0) check("overflow_cleared", 64'(overflow), 64'd0);
      event_in = (k <= total) ? ev_q[k-1] : 1'b0;
      trigger  = (retrig && k <= total) ? 1'($urandom_range(1)) : 1'b0;
      gate_len = (k <= total) ? GW'($urandom) : GW'(gl);
      num_bins = (k <= total) ? BW'($urandom) : BW'(nb);
      if (rand_ready) tready = (k % 4 == 0) ? 1'b1 : 1'($urandom_range(1));
      step();
    end
    check("busy_cycles", 64'(busy_seen), 64'(total));
    check("done_pulses", 64'(done_seen), (nb != 0) ? 64'd1 : 64'd0);
    if (nb != 0) check("done_cycle", 64'(done_at), 64'(total + 1));
    gate_len = GW'(gl);
    num_bins = BW'(nb);
  endtask

  task automatic drain();
    int n;
    tready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", sb.size());
      sb.delete();
    end
    step();
    check("tvalid_after_drain", 64'(tvalid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; event_in = 1'b0; trigger = 1'b0; tready = 1'b1;
    gate_len = '0; num_bins = '0;
    s_event = 1'b1; s_trigger = 1'b0; s_gate = 8'd20; s_bins = 4'd2;
    step(); step();
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    step();

    // Saturation on the narrow instance: 20 events per bin exceed a 4-bit count
    s_trigger = 1'b1;
    step();
    s_trigger = 1'b0;
    repeat (45) step();
    check("sat_words", 64'(s_got.size()), 64'd2);
    for (int b = 0; b < 2 && b < s_got.size(); b++) begin
      int c;
      c = (20 > 15) ? 15 : 20;
      check("sat_word", 64'(s_got[b]), 64'({4'(b), 4'(c)}));
    end

    // Basic: events at cycles 2,5,21,29 after the trigger edge
    ev_q.delete();
    for (int k = 1; k <= 30; k++) ev_q.push_back(k == 2 || k == 5 || k == 21 || k == 29);
    acquire(10, 3, 1'b0, 1'b0, 1'b0, 3);
    drain();

    // Bin boundary with an uncounted trigger-cycle event
    ev_q.delete();
    for (int k = 1; k <= 8; k++) ev_q.push_back(k == 4 || k == 5);
    acquire(4, 2, 1'b1, 1'b0, 1'b0, 2);
    drain();

    // Backpressure: only the first FD words survive, overflow is sticky
    tready = 1'b0;
    fill_rand(6, 50);
    acquire(1, 6, 1'b0, 1'b0, 1'b0, FD);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_tvalid", 64'(tvalid), 64'd1);
    repeat (3) step();
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);

    // num_bins = 0: trigger ignored
    ev_q.delete();
    acquire(5, 0, 1'b1, 1'b0, 1'b0, 0);
    check("nb0_tvalid", 64'(tvalid), 64'd0);
    check("nb0_overflow_kept", 64'(overflow), 64'd1);

    // gate_len = 0 behaves as 1-cycle bins
    fill_rand(5, 60);
    acquire(0, 5, 1'b0, 1'b0, 1'b0, 5);
    drain();

    // Retrigger during COUNT ignored
    fill_rand(24, 40);
    acquire(6, 4, 1'b1, 1'b1, 1'b0, 4);
    drain();

    // Randomized acquisitions under random (but never overflowing) backpressure
    for (int it = 0; it < 6; it++) begin
      int gl, nb;
      gl = int'($urandom_range(20, 8));
      nb = int'($urandom_range(5, 1));
      fill_rand(gl * nb, 50);
      acquire(gl, nb, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, nb);
      drain();
      check("rand_no_overflow", 64'(overflow), 64'd0);
    end

    // Reset mid-run in bin 2 with two words queued
    tready = 1'b0;
    gate_len = GW'(5);
    num_bins = BW'(6);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      event_in = 1'($urandom_range(1));
      step();
    end
    event_in = 1'b0;
    check("pre_rst_tvalid", 64'(tvalid), 64'd1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_tdata", 64'(tdata), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    repeat (3) step();
    check("post_rst_idle", 64'(tvalid), 64'd0);
    tready = 1'b1;
    fill_rand(6, 50);
    acquire(3, 2, 1'b0, 1'b0, 1'b0, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
